mul_share_arb: RTL and testbench

Round-robin arbiter that time-shares the power unit's single 12-bit sequential Q10 multiplier (start/ain/bin/yout/done interface) between N_REQ requesters, such as per-channel V*I power and gain-scaling paths. It grants one requester at a time and launches the multiplier with that requester's operands. It returns the scaled product with a one-cycle ack and guards against a hung multiplier with a timeout.

---
 rtl/mul_share_arb.sv | 127 ++++++++++++
 tb/tb_mul_share_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one sequential Q10 multiplier among N_REQ requesters,
// with a per-transaction watchdog that aborts a hung multiplier.
module mul_share_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 12,
    parameter int unsigned TIMEOUT = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*DW-1:0]   a_i,
    input  logic [N_REQ*DW-1:0]   b_i,
    output logic [N_REQ-1:0]      ack_o,
    output logic [DW-1:0]         result_o,
    output logic                  timeout_err_o,
    output logic                  busy_o,
    output logic                  mul_start_o,
    output logic [DW-1:0]         mul_a_o,
    output logic [DW-1:0]         mul_b_o,
    input  logic [DW-1:0]         mul_y_i,
    input  logic                  mul_done_i
);

    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t             state_q;
    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      last_grant_q;
    logic [CW-1:0]      cnt_q;
    logic [N_REQ-1:0]   ack_q;
    logic [DW-1:0]      result_q;
    logic               timeout_err_q;
    logic               busy_q;
    logic               mul_start_q;
    logic [DW-1:0]      mul_a_q;
    logic [DW-1:0]      mul_b_q;

    logic               pick_valid_c;
    logic [GW-1:0]      pick_idx_c;

    // First pending request searching upward from the one after the last grant.
    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            int unsigned cand;
            cand = (32'(last_grant_q) + i) % N_REQ;
            if (!pick_valid_c && req_i[GW'(cand)]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = GW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(N_REQ - 1);
            cnt_q         <= '0;
            ack_q         <= '0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
        end else begin
            mul_start_q   <= 1'b0;
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid_c) begin
                        grant_q     <= pick_idx_c;
                        mul_a_q     <= a_i[32'(pick_idx_c)*DW +: DW];
                        mul_b_q     <= b_i[32'(pick_idx_c)*DW +: DW];
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (mul_done_i) begin
                        result_q <= mul_y_i;
                        ack_q    <= N_REQ'(1) << grant_q;
                        state_q  <= S_DELIVER;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        result_q      <= '0;
                        timeout_err_q <= 1'b1;
                        ack_q         <= N_REQ'(1) << grant_q;
                        state_q       <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign result_o      = result_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = busy_q;
    assign mul_start_o   = mul_start_q;
    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a behavioural Q10 multiplier stub
// whose latency and stuck-done behaviour are controllable.
module tb_mul_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 12;
    localparam int unsigned TO = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_i;
    logic [N*DW-1:0]   a_i;
    logic [N*DW-1:0]   b_i;
    logic [N-1:0]      ack_o;
    logic [DW-1:0]     result_o;
    logic              timeout_err_o;
    logic              busy_o;
    logic              mul_start_o;
    logic [DW-1:0]     mul_a_o;
    logic [DW-1:0]     mul_b_o;
    logic [DW-1:0]     mul_y;
    logic              mul_done;

    mul_share_arb #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .ack_o        (ack_o),
        .result_o     (result_o),
        .timeout_err_o(timeout_err_o),
        .busy_o       (busy_o),
        .mul_start_o  (mul_start_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_y_i      (mul_y),
        .mul_done_i   (mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier stub: latches operands on start, pulses done lat cycles later.
    int          lat   = 4;
    bit          stuck = 1'b0;
    int          mcnt;
    logic        mactive;
    logic [DW-1:0] ma, mb;
    logic [23:0] prod;
    assign prod = 24'(ma) * 24'(mb);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mactive  <= 1'b0;
            mcnt     <= 0;
            mul_done <= 1'b0;
            mul_y    <= '0;
            ma       <= '0;
            mb       <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start_o) begin
                mactive <= 1'b1;
                mcnt    <= 0;
                ma      <= mul_a_o;
                mb      <= mul_b_o;
            end else if (mactive) begin
                mcnt <= mcnt + 1;
                if (mcnt == lat - 1) begin
                    mactive <= 1'b0;
                    if (!stuck) begin
                        mul_done <= 1'b1;
                        mul_y    <= prod[21:10];
                    end
                end
            end
        end
    end

    int start_cnt    = 0;
    int restart_viol = 0;
    always @(negedge clk) begin
        if (rst_n && mul_start_o) begin
            start_cnt++;
            if (mactive) restart_viol++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_i[idx*DW +: DW] = a;
        b_i[idx*DW +: DW] = b;
    endtask

    task automatic wait_ack(output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        while (cyc < 200 && !ok) begin
            @(negedge clk);
            cyc++;
            if (ack_o != '0) ok = 1'b1;
        end
        if (!ok) check("ack_wait_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_start();
        bit ok;
        int cyc;
        ok  = 1'b0;
        cyc = 0;
        while (cyc < 50 && !ok) begin
            @(negedge clk);
            cyc++;
            if (mul_start_o) ok = 1'b1;
        end
        if (!ok) check("start_wait_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] y;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int s0;
        req_i = '0;
        a_i   = '0;
        b_i   = '0;

        tbl[0] = '{0, 12'h400, 12'h200, 12'h200};
        tbl[1] = '{1, 12'h800, 12'h300, 12'h600};
        tbl[2] = '{2, 12'hFFF, 12'hFFF, 12'hFF8};
        tbl[3] = '{3, 12'h001, 12'h3FF, 12'h000};
        tbl[4] = '{0, 12'h600, 12'h600, 12'h900};

        do_reset();
        check("rst_ack",       32'(ack_o),         32'd0);
        check("rst_result",    32'(result_o),      32'd0);
        check("rst_terr",      32'(timeout_err_o), 32'd0);
        check("rst_busy",      32'(busy_o),        32'd0);
        check("rst_start",     32'(mul_start_o),   32'd0);
        check("rst_mul_a",     32'(mul_a_o),       32'd0);
        check("rst_mul_b",     32'(mul_b_o),       32'd0);

        // Single request with detailed timing.
        s0 = start_cnt;
        set_op(0, 12'h400, 12'h200);
        req_i = 4'b0001;
        wait_start();
        check("single_mul_a", 32'(mul_a_o), 32'h400);
        check("single_mul_b", 32'(mul_b_o), 32'h200);
        cyc = 0;
        while (!mul_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("single_ack_early", 32'(ack_o), 32'd0);
        @(negedge clk);
        check("single_ack",    32'(ack_o),         32'b0001);
        check("single_result", 32'(result_o),      32'h200);
        check("single_terr",   32'(timeout_err_o), 32'd0);
        req_i = '0;
        @(negedge clk);
        check("single_ack_one_cycle", 32'(ack_o), 32'd0);
        check("single_start_count", 32'(start_cnt - s0), 32'd1);
        @(negedge clk);

        // Table of single-requester transactions.
        for (int v = 0; v < 5; v++) begin
            set_op(tbl[v].idx, tbl[v].a, tbl[v].b);
            req_i[tbl[v].idx] = 1'b1;
            wait_ack(cyc);
            check($sformatf("tbl%0d_ack", v),    32'(ack_o),         32'(1) << tbl[v].idx);
            check($sformatf("tbl%0d_result", v), 32'(result_o),      32'(tbl[v].y));
            check($sformatf("tbl%0d_terr", v),   32'(timeout_err_o), 32'd0);
            req_i = '0;
            @(negedge clk);
            check($sformatf("tbl%0d_ack_clr", v), 32'(ack_o), 32'd0);
            check($sformatf("tbl%0d_hold", v),    32'(result_o), 32'(tbl[v].y));
        end

        // Simultaneous requests: round robin from requester 0.
        do_reset();
        s0 = start_cnt;
        for (int k = 0; k < 4; k++) set_op(k, 12'(k + 1), 12'h400);
        req_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc);
            check($sformatf("simul%0d_ack", k),    32'(ack_o),    32'(1) << k);
            check($sformatf("simul%0d_result", k), 32'(result_o), 32'(k + 1));
            req_i[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("simul_start_count", 32'(start_cnt - s0), 32'd4);
        check("simul_busy_idle",   32'(busy_o),         32'd0);

        // Fairness between two continuously requesting channels.
        do_reset();
        set_op(0, 12'h400, 12'h001);
        set_op(2, 12'h400, 12'h002);
        req_i = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            wait_ack(cyc);
            check($sformatf("fair%0d_ack", k), 32'(ack_o), (k % 2 == 0) ? 32'b0001 : 32'b0100);
            if (k == 5) req_i = '0;
        end
        repeat (3) @(negedge clk);

        // Timeout: done never arrives, ack 24 cycles after leaving LAUNCH.
        stuck = 1'b1;
        set_op(2, 12'h400, 12'h400);
        req_i = 4'b0100;
        wait_start();
        wait_ack(cyc);
        check("to_latency", 32'(cyc),           32'd25);
        check("to_ack",     32'(ack_o),         32'b0100);
        check("to_result",  32'(result_o),      32'd0);
        check("to_terr",    32'(timeout_err_o), 32'd1);
        req_i = '0;
        @(negedge clk);
        check("to_terr_clr", 32'(timeout_err_o), 32'd0);
        stuck = 1'b0;
        set_op(2, 12'h400, 12'h100);
        req_i = 4'b0100;
        wait_ack(cyc);
        check("to_recover_result", 32'(result_o),      32'h100);
        check("to_recover_terr",   32'(timeout_err_o), 32'd0);
        req_i = '0;
        @(negedge clk);

        // Done coincides with the last watchdog cycle: success wins.
        lat = TO - 1;
        set_op(0, 12'h400, 12'h155);
        req_i = 4'b0001;
        wait_start();
        wait_ack(cyc);
        check("coll_latency", 32'(cyc),           32'd25);
        check("coll_result",  32'(result_o),      32'h155);
        check("coll_terr",    32'(timeout_err_o), 32'd0);
        req_i = '0;
        lat = 4;
        @(negedge clk);

        // Reset during WAIT: last_grant returns to N-1 so requester 1 beats 3.
        set_op(1, 12'h400, 12'h300);
        req_i = 4'b0010;
        wait_ack(cyc);
        check("prerst_result", 32'(result_o), 32'h300);
        req_i = '0;
        @(negedge clk);
        set_op(1, 12'h400, 12'h080);
        set_op(3, 12'h400, 12'h040);
        req_i = 4'b0010;
        wait_start();
        repeat (3) @(negedge clk);
        check("midwait_busy", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(busy_o),   32'd0);
        check("async_rst_result", 32'(result_o), 32'd0);
        check("async_rst_mul_a",  32'(mul_a_o),  32'd0);
        check("async_rst_ack",    32'(ack_o),    32'd0);
        repeat (2) @(negedge clk);
        check("in_rst_ack", 32'(ack_o), 32'd0);
        req_i = 4'b1010;
        rst_n = 1'b1;
        wait_ack(cyc);
        check("postrst_ack0",    32'(ack_o),    32'b0010);
        check("postrst_result0", 32'(result_o), 32'h080);
        req_i[1] = 1'b0;
        wait_ack(cyc);
        check("postrst_ack1",    32'(ack_o),    32'b1000);
        check("postrst_result1", 32'(result_o), 32'h040);
        req_i = '0;
        repeat (3) @(negedge clk);

        check("no_restart_in_wait", 32'(restart_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
